// File: rtl/repl_policy.sv
// Cache replacement-policy unit: per-set valid bits plus exact-LRU ages, FIFO
// pointers or a shared 16-bit LFSR, selecting a victim way for the addressed set.
module repl_policy #(
  parameter int          WAYS      = 4,
  parameter int          SETS      = 32,
  parameter int          MODE      = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [$clog2(SETS)-1:0] index,
  input  logic                    access,
  input  logic [$clog2(WAYS)-1:0] hit_way,
  input  logic                    fill,
  input  logic                    flush,
  output logic [$clog2(WAYS)-1:0] victim_way,
  output logic                    set_full
);

  localparam int WW = $clog2(WAYS);

  logic [WAYS-1:0] valid_q [SETS];
  logic [WW-1:0]   age_q   [SETS][WAYS];
  logic [WW-1:0]   ptr_q   [SETS];
  logic [15:0]     lfsr_q;

  logic [WAYS-1:0] cur_valid;
  logic            free_found;
  logic [WW-1:0]   free_way;
  logic [WW-1:0]   lru_way;
  logic [WW-1:0]   policy_way;
  logic            upd_en;
  logic [WW-1:0]   upd_way;
  logic [WW-1:0]   upd_age;
  logic            lfsr_fb;

  always_comb begin
    cur_valid  = valid_q[index];
    set_full   = &cur_valid;
    free_found = 1'b0;
    free_way   = '0;
    // Descending scan so the lowest invalid way is the one left standing.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!cur_valid[w]) begin
        free_found = 1'b1;
        free_way   = WW'(w);
      end
    end
    lru_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[index][w] == WW'(WAYS - 1)) lru_way = WW'(w);
    end
    if (MODE == 1)      policy_way = ptr_q[index];
    else if (MODE == 2) policy_way = lfsr_q[WW-1:0];
    else                policy_way = lru_way;
    victim_way = free_found ? free_way : policy_way;
  end

  // A fill touches the victim it installs; it takes priority over an access.
  always_comb begin
    upd_en  = fill | access;
    upd_way = fill ? victim_way : hit_way;
    upd_age = age_q[index][upd_way];
    lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= WW'(w);
      end
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
      if (MODE == 0 && upd_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WW'(w) == upd_way)          age_q[index][w] <= '0;
          else if (age_q[index][w] < upd_age) age_q[index][w] <= age_q[index][w] + WW'(1);
        end
      end
      if (MODE == 1 && fill && set_full) ptr_q[index] <= ptr_q[index] + WW'(1);
      if (flush) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end else if (fill) begin
        valid_q[index][victim_way] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_repl_policy.sv
// Bench for repl_policy: LRU, FIFO and random instances share one stimulus
// stream and are checked against a timestamp/counter based reference model.
module tb_repl_policy;

  localparam int          WAYS = 4;
  localparam int          SETS = 32;
  localparam int          WW   = 2;
  localparam int          SW   = 5;
  localparam int          W    = 3 * WW + 1;
  localparam logic [15:0] SEED = 16'hACE1;

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [SW-1:0] index = '0;
  logic          access = 1'b0;
  logic [WW-1:0] hit_way = '0;
  logic          fill = 1'b0;
  logic          flush = 1'b0;
  logic [WW-1:0] v_lru, v_fifo, v_rnd;
  logic          f_lru, f_fifo, f_rnd;

  repl_policy #(.WAYS(WAYS), .SETS(SETS), .MODE(0), .LFSR_SEED(SEED)) u_lru (
    .clk(clk), .rstn(rstn), .index(index), .access(access), .hit_way(hit_way),
    .fill(fill), .flush(flush), .victim_way(v_lru), .set_full(f_lru));
  repl_policy #(.WAYS(WAYS), .SETS(SETS), .MODE(1), .LFSR_SEED(SEED)) u_fifo (
    .clk(clk), .rstn(rstn), .index(index), .access(access), .hit_way(hit_way),
    .fill(fill), .flush(flush), .victim_way(v_fifo), .set_full(f_fifo));
  repl_policy #(.WAYS(WAYS), .SETS(SETS), .MODE(2), .LFSR_SEED(SEED)) u_rnd (
    .clk(clk), .rstn(rstn), .index(index), .access(access), .hit_way(hit_way),
    .fill(fill), .flush(flush), .victim_way(v_rnd), .set_full(f_rnd));

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];
  int rnd_hist[WAYS];
  bit rnd_count_en = 1'b0;

  // Reference model: last-touch timestamps, fill counters, plain LFSR.
  int          ts[SETS][WAYS];
  int          tnow;
  bit          vld[SETS][WAYS];
  int          fifo_cnt[SETS];
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    // x^16+x^14+x^13+x^11+1: exponent e taps bit e-1
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic int lowest_invalid(input int s);
    for (int w = 0; w < WAYS; w++) if (!vld[s][w]) return w;
    return -1;
  endfunction

  function automatic int model_victim(input int mode, input int s);
    int f;
    int best;
    f = lowest_invalid(s);
    if (f >= 0) return f;
    if (mode == 0) begin
      best = 0;
      for (int w = 1; w < WAYS; w++) if (ts[s][w] < ts[s][best]) best = w;
      return best;
    end
    if (mode == 1) return fifo_cnt[s] % WAYS;
    return int'(m_lfsr) % WAYS;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      fifo_cnt[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        vld[s][w] = 1'b0;
        ts[s][w]  = WAYS - 1 - w;
      end
    end
    tnow   = WAYS;
    m_lfsr = SEED;
  endfunction

  // driver tasks
  task automatic reset_cycles(input int n, input bit strobes);
    rstn   = 1'b0;
    access = strobes;
    fill   = strobes;
    flush  = 1'b0;
    repeat (n) @(posedge clk);
    model_reset();
    #1;
    rstn   = 1'b1;
    access = 1'b0;
    fill   = 1'b0;
  endtask

  task automatic cycle(input int s, input bit acc, input int hw, input bit fl, input bit fsh);
    int v0, v1, v2;
    bit full;
    logic [WW-1:0] e0, e1, e2;
    index   = SW'(s);
    access  = acc;
    hit_way = WW'(hw);
    fill    = fl;
    flush   = fsh;
    v0 = model_victim(0, s);
    v1 = model_victim(1, s);
    v2 = model_victim(2, s);
    full = (lowest_invalid(s) < 0);
    e0 = WW'(v0);
    e1 = WW'(v1);
    e2 = WW'(v2);
    exp_q.push_back({e0, e1, e2, full});
    @(posedge clk);
    m_lfsr = lfsr_next(m_lfsr);
    if (fl) begin
      ts[s][v0] = tnow;
      tnow++;
      if (full) fifo_cnt[s]++;
      if (!fsh) vld[s][v0] = 1'b1;
    end else if (acc) begin
      ts[s][hw] = tnow;
      tnow++;
    end
    if (fsh) for (int a = 0; a < SETS; a++) for (int w = 0; w < WAYS; w++) vld[a][w] = 1'b0;
    #1;
  endtask

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s at %0t index=%0d: got %0d, expected %0d", name, $time, index, got, want);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("lru_victim",  int'(v_lru),  int'(e[3*WW -: WW]));
      check("fifo_victim", int'(v_fifo), int'(e[2*WW -: WW]));
      check("rnd_victim",  int'(v_rnd),  int'(e[WW -: WW]));
      check("lru_full",    int'(f_lru),  int'(e[0]));
      check("fifo_full",   int'(f_fifo), int'(e[0]));
      check("rnd_full",    int'(f_rnd),  int'(e[0]));
      if (rnd_count_en) rnd_hist[v_rnd]++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    for (int w = 0; w < WAYS; w++) rnd_hist[w] = 0;
    reset_cycles(2, 1'b0);
    cycle(5, 0, 0, 0, 0);
    // fill set 3 from empty, then confirm set 5 is untouched
    for (int i = 0; i < WAYS; i++) cycle(3, 0, 0, 1, 0);
    cycle(3, 0, 0, 0, 0);
    cycle(5, 0, 0, 0, 0);
    // LRU ordering
    cycle(3, 1, 0, 0, 0);
    cycle(3, 1, 2, 0, 0);
    cycle(3, 1, 1, 0, 0);
    cycle(3, 1, 3, 0, 0);
    cycle(3, 0, 0, 0, 0);
    cycle(3, 1, 0, 0, 0);
    cycle(3, 0, 0, 0, 0);
    // FIFO sequence with interleaved accesses, through the wrap
    cycle(3, 0, 0, 1, 0);
    cycle(3, 1, 2, 0, 0);
    cycle(3, 0, 0, 1, 0);
    cycle(3, 1, 2, 0, 0);
    cycle(3, 0, 0, 1, 0);
    cycle(3, 1, 2, 0, 0);
    cycle(3, 0, 0, 1, 0);
    cycle(3, 0, 0, 0, 0);
    // random victim distribution on a full set
    rnd_count_en = 1'b1;
    repeat (4096) cycle(3, 0, 0, 0, 0);
    rnd_count_en = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      vectors++;
      if (rnd_hist[w] < 800) begin
        miscompares++;
        $display("FAIL rnd_hist way %0d: got %0d hits, expected at least 800", w, rnd_hist[w]);
      end
    end
    // flush together with a fill on a full set, then refill
    cycle(3, 0, 0, 1, 1);
    cycle(3, 0, 0, 0, 0);
    cycle(5, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(31, 0, 0, 0, 0);
    for (int i = 0; i < WAYS; i++) cycle(3, 0, 0, 1, 0);
    cycle(3, 0, 0, 0, 0);
    // random soak biased toward a few sets so they fill up
    reset_cycles(1, 1'b0);
    repeat (10000) begin
      s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, SETS - 1)) : int'($urandom_range(0, 3));
      cycle(s, $urandom_range(0, 1) == 1, int'($urandom_range(0, WAYS - 1)),
            $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);
    end
    // reset asserted with strobes active
    reset_cycles(1, 1'b1);
    cycle(3, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(17, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
